// File: rtl/io_port_responder.sv
// Output-port FIFO (first-word fall-through, valid/ready drain) plus optional input holding register.
// Macro IO_INPUT_PORT_EN enables the input-side FSM; without it the input handshake is tied off.
module io_port_responder #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4,
    parameter int ADDR_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              OutWrite,
    input  logic [DATA_W-1:0] DataOut,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_full,
    output logic [ADDR_W:0]   out_count,
    output logic              overflow,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              InRead,
    output logic [DATA_W-1:0] din,
    output logic              in_empty
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(OUT_DEPTH);

    logic [DATA_W-1:0] mem [OUT_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push, pop;

    assign out_valid = (count != '0);
    assign out_full  = (count == FULL_CNT);
    assign out_count = count;
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push      = OutWrite & (~out_full | pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= DataOut;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (OutWrite && !push) overflow <= 1'b1;
        end
    end

`ifdef IO_INPUT_PORT_EN
    // state    | meaning
    // IN_EMPTY | no word held, in_ready=1, din=0
    // IN_FULL  | din holds a captured word awaiting InRead
    typedef enum logic {IN_EMPTY, IN_FULL} in_state_t;

    in_state_t         state, state_nxt;
    logic [DATA_W-1:0] din_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IN_EMPTY;
            din_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IN_EMPTY && in_valid) din_q <= in_data;
            else if (state == IN_FULL && InRead) din_q <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        in_empty  = 1'b0;
        case (state)
            IN_EMPTY: begin
                in_ready = 1'b1;
                in_empty = 1'b1;
                if (in_valid) state_nxt = IN_FULL;
            end
            IN_FULL: begin
                // in_valid is not looked at here: a consumed slot reopens next cycle
                if (InRead) state_nxt = IN_EMPTY;
            end
            default: state_nxt = IN_EMPTY;
        endcase
    end

    assign din = din_q;
`else
    logic unused_in;
    assign unused_in = ^{in_data, in_valid, InRead};
    assign in_ready  = 1'b0;
    assign din       = '0;
    assign in_empty  = 1'b1;
`endif

endmodule
